pcie_cap_list_walker: RTL

- Hardware walker for PCI config space that traverses a capability linked list and returns the byte offset of the first structure matching a requested capability ID.
- Parametrised successor to the static capability register definitions. One instance handles either the legacy PCI list (pointer at 0x34, 8-bit ID and next pointer) or the PCIe extended list (header at 0x100, 16-bit ID and 12-bit next pointer).
- Sits between firmware/enumeration logic and the config-space register file.
- Issues dword reads over a simple req/ack interface.
- Includes loop protection and pointer validation.

---
 rtl/pcie_cap_list_walker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pcie_cap_list_walker.sv
// Walks the PCI (legacy) or PCIe (extended) capability list through a req/ack
// dword read port and reports the offset of the first header matching target_id_i.
module pcie_cap_list_walker #(
    parameter int unsigned EXT_CAP  = 0,
    parameter int unsigned MAX_HOPS = 48,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       target_id_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              found_o,
    output logic [ADDR_W-1:0] cap_offset_o,
    output logic [7:0]        hops_o,
    output logic [1:0]        err_o,
    output logic              cfg_rd_req_o,
    output logic [ADDR_W-1:0] cfg_rd_addr_o,
    input  logic              cfg_rd_ack_i,
    input  logic [31:0]       cfg_rd_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STATUS,
        RD_PTR,
        RD_HDR,
        FIN
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HOPS = 2'd1;
    localparam logic [1:0] ERR_PTR  = 2'd2;

    localparam logic [ADDR_W-1:0] LIST_BASE  = (EXT_CAP != 0) ? ADDR_W'(32'h100) : ADDR_W'(32'h40);
    localparam logic [ADDR_W-1:0] STATUS_ADR = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] CAPPTR_ADR = ADDR_W'(32'h34);
    localparam logic [7:0]        HOP_LIMIT  = 8'(MAX_HOPS);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                found_q, found_d;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [7:0]          hops_q, hops_d;
    logic [1:0]          err_q, err_d;

    logic                xfer;
    logic [7:0]          cap_ptr;
    logic                hdr_match;
    logic                hdr_empty;
    logic [ADDR_W-1:0]   hdr_nxt;
    logic                unused_sink;

    assign xfer        = req_q & cfg_rd_ack_i;
    assign cap_ptr     = cfg_rd_data_i[7:0] & 8'hFC;
    assign unused_sink = ^{cfg_rd_data_i, target_id_i};

    // Header layout differs between list flavours; next pointer is always dword aligned.
    always_comb begin
        if (EXT_CAP != 0) begin
            hdr_match = (cfg_rd_data_i[15:0] == target_id_i);
            hdr_nxt   = ADDR_W'({cfg_rd_data_i[31:22], 2'b00});
            hdr_empty = (cfg_rd_data_i == '0) && (ptr_q == LIST_BASE);
        end else begin
            hdr_match = (cfg_rd_data_i[7:0] == target_id_i[7:0]);
            hdr_nxt   = ADDR_W'({cfg_rd_data_i[15:10], 2'b00});
            hdr_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ptr_q   <= '0;
            found_q <= 1'b0;
            off_q   <= '0;
            hops_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            found_q <= found_d;
            off_q   <= off_d;
            hops_q  <= hops_d;
            err_q   <= err_d;
        end
    end

    // Each read state raises req on entry (req_q low) and acts on the completing ack,
    // dropping req so there is always an idle cycle between reads.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        found_d = found_q;
        off_d   = off_q;
        hops_d  = hops_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    found_d = 1'b0;
                    off_d   = '0;
                    hops_d  = '0;
                    err_d   = ERR_NONE;
                    if (EXT_CAP != 0) begin
                        state_d = RD_HDR;
                        ptr_d   = LIST_BASE;
                    end else begin
                        state_d = RD_STATUS;
                    end
                end
            end

            RD_STATUS: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = STATUS_ADR;
                end else if (xfer) begin
                    req_d   = 1'b0;
                    state_d = cfg_rd_data_i[20] ? RD_PTR : FIN;
                end
            end

            RD_PTR: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = CAPPTR_ADR;
                end else if (xfer) begin
                    req_d = 1'b0;
                    if (cap_ptr == 8'h00) begin
                        state_d = FIN;
                    end else if (cap_ptr < 8'h40) begin
                        err_d   = ERR_PTR;
                        state_d = FIN;
                    end else begin
                        ptr_d   = ADDR_W'(cap_ptr);
                        state_d = RD_HDR;
                    end
                end
            end

            RD_HDR: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = ptr_q;
                end else if (xfer) begin
                    req_d   = 1'b0;
                    hops_d  = hops_q + 8'd1;
                    state_d = FIN;
                    if (hdr_empty) begin
                        found_d = 1'b0;
                    end else if (hdr_match) begin
                        found_d = 1'b1;
                        off_d   = ptr_q;
                    end else if (hdr_nxt == '0) begin
                        found_d = 1'b0;
                    end else if (hdr_nxt < LIST_BASE) begin
                        err_d = ERR_PTR;
                    end else if (hops_d == HOP_LIMIT) begin
                        err_d = ERR_HOPS;
                    end else begin
                        ptr_d   = hdr_nxt;
                        state_d = RD_HDR;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign busy_o        = (state_q == RD_STATUS) || (state_q == RD_PTR) || (state_q == RD_HDR);
    assign done_o        = (state_q == FIN);
    assign found_o       = found_q;
    assign cap_offset_o  = off_q;
    assign hops_o        = hops_q;
    assign err_o         = err_q;
    assign cfg_rd_req_o  = req_q;
    assign cfg_rd_addr_o = addr_q;

endmodule
